// File: rtl/bf16_pkg.sv
// bf16_pkg: shared float-format constants and converter state type
package bf16_pkg;
    localparam int BF16_BIAS = 127;
    localparam int BF16_EXP_W = 8;
    localparam int BF16_FRAC_W = 7;
    localparam int E4M3_BIAS = 7;
    localparam int E4M3_EXP_W = 4;
    localparam int E4M3_FRAC_W = 3;
    localparam logic [7:0] E4M3_MAX = 8'h7E;
    localparam logic [7:0] E4M3_NAN = 8'h7F;
    typedef enum logic [1:0] {IDLE, NORM, ROUND} cvt_state_t;
endpackage

// File: rtl/bf16_rne_round.sv
// bf16_rne_round: round-to-nearest-even on a 7-bit fraction, carrying into the exponent
module bf16_rne_round import bf16_pkg::*; (
    input  logic [BF16_FRAC_W-1:0] frac,
    input  logic                   guard,
    input  logic                   sticky,
    input  logic [BF16_EXP_W-1:0]  exp,
    output logic [BF16_FRAC_W-1:0] frac_rnd,
    output logic [BF16_EXP_W-1:0]  exp_rnd
);
    logic [BF16_FRAC_W:0] sum;
    // a fraction carry-out leaves the low bits at zero and bumps the exponent
    always_comb begin
        sum = {1'b0, frac} + {{BF16_FRAC_W{1'b0}}, guard & (sticky | frac[0])};
        frac_rnd = sum[BF16_FRAC_W-1:0];
        exp_rnd = exp + {{(BF16_EXP_W-1){1'b0}}, sum[BF16_FRAC_W]};
    end
endmodule

// File: rtl/int_to_float_bf16.sv
// int_to_float_bf16: iterative signed integer to bf16 converter, one normalise step per cycle
module int_to_float_bf16 import bf16_pkg::*; #(
    parameter int INT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [INT_W-1:0] a,
    output logic [15:0]      y,
    output logic             busy,
    output logic             is_output_valid
);
    localparam logic [BF16_EXP_W-1:0] EXP_INIT = BF16_EXP_W'(BF16_BIAS + INT_W - 1);
    cvt_state_t state;
    logic sign, zero;
    logic [INT_W-1:0] mag, mag_in;
    logic [BF16_EXP_W-1:0] exp, exp_rnd;
    logic [INT_W:0] ext;
    logic [BF16_FRAC_W-1:0] frac_rnd;
    // magnitude as unsigned INT_W so the most negative input maps to 2^(INT_W-1);
    // ext drops the hidden bit and pads two zeros so guard/sticky exist for INT_W=8
    always_comb begin
        mag_in = a[INT_W-1] ? -a : a;
        ext = {mag[INT_W-2:0], 2'b00};
    end
    bf16_rne_round u_round (
        .frac     (ext[INT_W -: BF16_FRAC_W]),
        .guard    (ext[INT_W-BF16_FRAC_W]),
        .sticky   (|ext[INT_W-BF16_FRAC_W-1:0]),
        .exp      (exp),
        .frac_rnd (frac_rnd),
        .exp_rnd  (exp_rnd)
    );
    // capture, shift left until the top bit is set, then round and publish
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            y <= '0;
            busy <= 1'b0;
            is_output_valid <= 1'b0;
            sign <= 1'b0;
            zero <= 1'b0;
            mag <= '0;
            exp <= '0;
        end else begin
            is_output_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sign <= a[INT_W-1];
                    mag <= mag_in;
                    exp <= EXP_INIT;
                    zero <= mag_in == '0;
                    busy <= 1'b1;
                    state <= mag_in == '0 ? ROUND : NORM;
                end
                NORM: if (mag[INT_W-1]) state <= ROUND;
                else begin
                    mag <= mag << 1;
                    exp <= exp - 8'd1;
                end
                ROUND: begin
                    y <= zero ? 16'h0000 : {sign, exp_rnd, frac_rnd};
                    is_output_valid <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
